sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares one asynchronous 32-bit SRAM chip (BaseRAM or ExtRAM) between the instruction-fetch requester and the data requester. It sequences each access with fixed read and write hold timing, and runs multi-beat read bursts. It drives the chip's control, address and data pins, with a tri-state enable for the data pins. The block sits between the core-side bus FSMs and the board SRAM pins; one instance is used per chip.

## Interface
- READ_HOLD, 2, cycles the SRAM stays enabled before read data is captured
- WRITE_HOLD, 3, hold counter top for a write (we_n low for counts 1..WRITE_HOLD-1)
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- i_req  in  1  fetch request, held until i_gnt
- i_addr  in  20  fetch word address
- i_len  in  4  fetch burst beats minus one
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid / i_rlast  out  1 / 1  fetch beat valid / final beat
- i_rdata  out  32  fetch beat data
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  20  data word address
- d_len  in  4  read burst beats minus one; ignored for writes
- d_be  in  4  active-high byte enables; all ones for reads
- d_wdata  in  32  write data
- d_gnt  out  1  data request accepted
- d_rvalid / d_rlast  out  1 / 1  data read beat valid / final beat
- d_rdata  out  32  data read beat
- d_bvalid  out  1  write completed, one-cycle pulse
- sram_addr  out  20;  sram_be_n  out  4;  sram_ce_n / sram_oe_n / sram_we_n  out  1 each
- sram_dout  out  32;  sram_dout_en  out  1  tri-state enable for the data pins
- sram_din  in  32  data pins as read back
- busy  out  1  high in every state except IDLE

## Operation
- States:
  - IDLE: waits for a request.
  - RD: hold counter 0..READ_HOLD.
  - RD_RESP: one cycle.
  - WR: hold counter 0..WRITE_HOLD.
  - WR_RESP: one cycle.
- IDLE:
  - If either request is high, grant one, latch its address, length, be and wdata, and clear the beat and hold counters.
  - Go to RD or WR. A write from the data requester goes to WR; all other accepted requests go to RD.
- Grant policy: the data requester always wins a simultaneous request.
- Grant pulse: the gnt output is combinational in the IDLE acceptance cycle only. The requester may drop req afterwards.
- RD:
  - ce_n=0, oe_n=0, be_n = ~latched be (0000 for fetch).
  - At count READ_HOLD, capture sram_din and go to RD_RESP.
- RD_RESP:
  - Assert the owner's rvalid with the captured data.
  - If the beat count equals len: assert rlast and go to IDLE.
  - Otherwise: increment the beat count, increment the address mod 2^20 (0xFFFFF wraps to 0x00000), clear the hold counter and return to RD.
- WR:
  - ce_n=0, dout_en=1, sram_dout = latched wdata, be_n = ~be.
  - we_n=0 only for counts 1..WRITE_HOLD-1, so address and data are set up one cycle before the we_n falling edge and held one cycle after its rising edge.
  - At count WRITE_HOLD go to WR_RESP.
- WR_RESP: d_bvalid=1, dout_en=0, then go to IDLE.
- Requesters cannot stall beats; rvalid lasts exactly one cycle.
- oe_n and we_n are never low in the same cycle. dout_en is never high while oe_n is low.

## Timing
- Reset (rst=0 at an edge) wins over every other input:
  - State goes to IDLE and counters clear.
  - ce_n, oe_n, we_n = 1; be_n = 1111; dout_en = 0; sram_addr = 0; sram_dout = 0.
  - All gnt, rvalid, rlast and bvalid = 0; rdata = 0; busy = 0.
- Reset mid-transaction abandons it: no further rvalid, rlast or bvalid is issued.
- Per read beat: READ_HOLD+2 cycles.
  - First rvalid arrives READ_HOLD+2 cycles after the grant cycle.
  - A full burst takes (len+1)·(READ_HOLD+2) cycles; back-to-back beats are spaced READ_HOLD+2 cycles apart.
- Write: bvalid arrives WRITE_HOLD+2 cycles after grant.
- After rlast or bvalid the block spends one IDLE cycle before the next grant, which gives one bus-turnaround cycle.
- SRAM pins and response outputs are decoded from registered state and counters, so they are glitch-free.

## Configuration
- SRAM_ARB_ROUND_ROBIN_EN defined:
  - On a simultaneous request, the requester not granted last wins.
  - A one-bit last-grant register resets to "fetch", so data wins the first tie.
- Not defined: fixed data-over-fetch priority and no last-grant register.

## Structure
- Put the state enum, the READ_HOLD/WRITE_HOLD defaults and a 20-bit sram_waddr_t typedef in the shared bundle package.
- Use one sub-module, sram_grant_picker: a combinational choice between the two requesters, plus the optional last-grant flop.

## Test plan
- Fetch, i_addr=0x00010, i_len=0 → i_gnt in the acceptance cycle; after 4 cycles, one i_rvalid+i_rlast with i_rdata = model word; oe_n low for 3 cycles.
- Data write, d_addr=0x00020, d_be=0011, wdata=0xAABBCCDD → be_n=1100; we_n low for 2 cycles framed by 1 setup and 1 hold cycle; d_bvalid at grant+5. Then reading the word back gives only the low half updated.
- Fetch burst, i_addr=0xFFFFE, i_len=3 → 4 beats at addresses FFFFE, FFFFF, 00000, 00001, spaced 4 cycles apart; rlast on beat 4 only.
- Both requests in one cycle, repeated twice, first without and then with the macro:
  - Without SRAM_ARB_ROUND_ROBIN_EN: data wins both times.
  - With it: data wins, then fetch wins.
- rst=0 during RD count 1 of a fetch → next cycle ce_n = oe_n = 1 and busy=0, and no i_rvalid ever follows.
- Random mixed traffic against an SRAM model → no cycle with oe_n=0 and we_n=0 together, or with dout_en=1 and oe_n=0; all read data matches the model.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and timing defaults for the SRAM port arbiter.
package sram_port_arbiter_pkg;

    localparam int READ_HOLD_DEF  = 2;
    localparam int WRITE_HOLD_DEF = 3;
    localparam int HOLD_W         = 4;

    typedef logic [19:0] sram_waddr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_RESP,
        ST_WR,
        ST_WR_RESP
    } arb_state_e;

endpackage

// File: rtl/sram_port_arbiter_grant_picker.sv
// Chooses fetch or data requester; optional last-grant flop under SRAM_ARB_ROUND_ROBIN_EN.
module sram_grant_picker (
    input  logic clk,
    input  logic rst,
    input  logic i_req_f,
    input  logic i_req_d,
    input  logic i_upd,
    output logic o_any,
    output logic o_pick_d
);

    assign o_any = i_req_f | i_req_d;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // 1 = data was granted last; resets to fetch so data wins the first tie
    logic r_last_d;

    always_ff @(posedge clk) begin
        if (!rst)
            r_last_d <= 1'b0;
        else if (i_upd)
            r_last_d <= o_pick_d;
    end

    assign o_pick_d = i_req_d & (~i_req_f | ~r_last_d);
`else
    logic w_unused;
    assign w_unused = ^{clk, rst, i_upd};
    assign o_pick_d = i_req_d;
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one async SRAM between fetch and data requesters with fixed hold timing.
// Optional round-robin tie break: define SRAM_ARB_ROUND_ROBIN_EN.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int READ_HOLD  = READ_HOLD_DEF,
    parameter int WRITE_HOLD = WRITE_HOLD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  sram_waddr_t i_addr,
    input  logic [3:0]  i_len,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic        i_rlast,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  sram_waddr_t d_addr,
    input  logic [3:0]  d_len,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic        d_rlast,
    output logic [31:0] d_rdata,
    output logic        d_bvalid,
    output sram_waddr_t sram_addr,
    output logic [3:0]  sram_be_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [31:0] sram_dout,
    output logic        sram_dout_en,
    input  logic [31:0] sram_din,
    output logic        busy
);

    localparam logic [HOLD_W-1:0] LP_RH = HOLD_W'(READ_HOLD);
    localparam logic [HOLD_W-1:0] LP_WH = HOLD_W'(WRITE_HOLD);

    arb_state_e        r_state, w_state_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [3:0]        r_beat, r_len, r_be;
    sram_waddr_t       r_addr;
    logic [31:0]       r_wdata, r_rdata;
    logic              r_own_d;
    logic              w_any, w_pick_d, w_acc;
    logic              w_rd, w_wr, w_rresp, w_last;

    assign w_acc = (r_state == ST_IDLE) & rst & w_any;

    sram_grant_picker u_pick (
        .clk      (clk),
        .rst      (rst),
        .i_req_f  (i_req),
        .i_req_d  (d_req),
        .i_upd    (w_acc),
        .o_any    (w_any),
        .o_pick_d (w_pick_d)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_any) w_state_nxt = (w_pick_d && d_we) ? ST_WR : ST_RD;
            ST_RD:      if (r_hold == LP_RH) w_state_nxt = ST_RD_RESP;
            ST_RD_RESP: w_state_nxt = (r_beat == r_len) ? ST_IDLE : ST_RD;
            ST_WR:      if (r_hold == LP_WH) w_state_nxt = ST_WR_RESP;
            ST_WR_RESP: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hold  <= '0;
            r_beat  <= '0;
            r_len   <= '0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_own_d <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_any) begin
                    r_own_d <= w_pick_d;
                    r_addr  <= w_pick_d ? d_addr : i_addr;
                    r_len   <= w_pick_d ? d_len : i_len;
                    r_be    <= w_pick_d ? d_be : 4'hF;
                    r_wdata <= d_wdata;
                    r_beat  <= '0;
                    r_hold  <= '0;
                end
                ST_RD: begin
                    r_hold <= r_hold + HOLD_W'(1);
                    if (r_hold == LP_RH)
                        r_rdata <= sram_din;
                end
                ST_RD_RESP: if (r_beat != r_len) begin
                    // address wraps naturally at 20 bits
                    r_beat <= r_beat + 4'd1;
                    r_addr <= r_addr + 20'd1;
                    r_hold <= '0;
                end
                ST_WR: r_hold <= r_hold + HOLD_W'(1);
                default: ;
            endcase
        end
    end

    assign w_rd    = (r_state == ST_RD);
    assign w_wr    = (r_state == ST_WR);
    assign w_rresp = (r_state == ST_RD_RESP);
    assign w_last  = (r_beat == r_len);

    assign i_gnt    = w_acc & ~w_pick_d;
    assign d_gnt    = w_acc & w_pick_d;
    assign i_rvalid = w_rresp & ~r_own_d;
    assign i_rlast  = w_rresp & ~r_own_d & w_last;
    assign d_rvalid = w_rresp & r_own_d;
    assign d_rlast  = w_rresp & r_own_d & w_last;
    assign i_rdata  = r_rdata;
    assign d_rdata  = r_rdata;
    assign d_bvalid = (r_state == ST_WR_RESP);
    assign busy     = (r_state != ST_IDLE);

    // we_n low only in the inner counts so addr/data frame the strobe on both sides
    assign sram_addr    = r_addr;
    assign sram_ce_n    = ~(w_rd | w_wr);
    assign sram_oe_n    = ~w_rd;
    assign sram_we_n    = ~(w_wr && (r_hold != '0) && (r_hold < LP_WH));
    assign sram_be_n    = (w_rd | w_wr) ? ~r_be : 4'hF;
    assign sram_dout_en = w_wr;
    assign sram_dout    = w_wr ? r_wdata : 32'h0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed + random bench for sram_port_arbiter with a transaction-timeline model.
module tb_sram_port_arbiter;

    localparam int RH   = 2;
    localparam int WH   = 3;
    localparam int MAXC = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [19:0] i_addr = '0, d_addr = '0;
    logic [3:0]  i_len = '0, d_len = '0, d_be = '0;
    logic [31:0] d_wdata = '0, sram_din = '0;
    logic        i_gnt, i_rvalid, i_rlast, d_gnt, d_rvalid, d_rlast, d_bvalid;
    logic [31:0] i_rdata, d_rdata, sram_dout;
    logic [19:0] sram_addr;
    logic [3:0]  sram_be_n;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, busy;

    sram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_be(d_be),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
        .d_rdata(d_rdata), .d_bvalid(d_bvalid),
        .sram_addr(sram_addr), .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_dout(sram_dout),
        .sram_dout_en(sram_dout_en), .sram_din(sram_din), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit        we;
        bit [19:0] addr;
        bit [3:0]  len;
        bit [3:0]  be;
        bit [31:0] wdata;
    } txn_t;

    typedef struct {
        bit        busy, ce, oe, we, den, iv, il, dv, dl, bv;
        bit [19:0] addr;
        bit [3:0]  ben;
        bit [31:0] dout, rdata;
    } exp_t;

    typedef struct {
        int        c;
        bit [31:0] data;
        bit        last;
        bit        isd;
    } beat_t;

    txn_t        fq[$], dq[$];
    exp_t        ex[MAXC];
    exp_t        e0;
    logic [31:0] chip[int];
    logic [31:0] gold[int];
    int          free_cyc = 0;
    bit          exp_ignt, exp_dgnt, chk_en;
    int          n_cmp = 0, n_err = 0;
    int          n_exp_beats = 0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    bit          m_last_d = 1'b0;
`endif

    // observation log for literal checks
    bit          grants[$];
    beat_t       beats[$];
    int          gnt_cyc, bv_cyc, we_cnt, we_first, oe_cnt;
    logic [3:0]  ben_seen;

    function automatic logic [31:0] init_word(input logic [19:0] a);
        return {12'hC0D, a};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = be[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] gold_rd(input logic [19:0] a);
        return gold.exists(int'(a)) ? gold[int'(a)] : init_word(a);
    endfunction

    function automatic logic [31:0] chip_rd(input logic [19:0] a);
        return chip.exists(int'(a)) ? chip[int'(a)] : init_word(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, expv, cyc);
        end
    endtask

    task automatic clr_log();
        grants.delete(); beats.delete();
        gnt_cyc = -1; bv_cyc = -1; we_cnt = 0; we_first = -1; oe_cnt = 0; ben_seen = 4'hx;
    endtask

    // expected pin/response timeline for one accepted transaction granted at g
    task automatic sched(input bit isd, input txn_t t);
        int g, base, idx;
        logic [19:0] a;
        g = cyc;
        if (isd && t.we) begin
            for (int h = 0; h <= WH; h++) begin
                idx = g + 1 + h;
                if (idx < MAXC) begin
                    ex[idx].busy = 1; ex[idx].ce = 1; ex[idx].den = 1;
                    ex[idx].addr = t.addr; ex[idx].ben = ~t.be; ex[idx].dout = t.wdata;
                    ex[idx].we = (h >= 1 && h <= WH - 1);
                end
            end
            idx = g + WH + 2;
            if (idx < MAXC) begin ex[idx].busy = 1; ex[idx].bv = 1; end
            gold[int'(t.addr)] = merge(gold_rd(t.addr), t.wdata, t.be);
            free_cyc = g + WH + 3;
        end else begin
            a = t.addr;
            for (int k = 0; k <= int'(t.len); k++) begin
                base = g + 1 + k * (RH + 2);
                for (int h = 0; h <= RH; h++) begin
                    idx = base + h;
                    if (idx < MAXC) begin
                        ex[idx].busy = 1; ex[idx].ce = 1; ex[idx].oe = 1;
                        ex[idx].addr = a; ex[idx].ben = ~t.be;
                    end
                end
                idx = base + RH + 1;
                if (idx < MAXC) begin
                    ex[idx].busy = 1; ex[idx].rdata = gold_rd(a);
                    if (isd) begin ex[idx].dv = 1; ex[idx].dl = (k == int'(t.len)); end
                    else     begin ex[idx].iv = 1; ex[idx].il = (k == int'(t.len)); end
                end
                n_exp_beats++;
                a = a + 20'd1;
            end
            free_cyc = g + (int'(t.len) + 1) * (RH + 2) + 1;
        end
    endtask

    task automatic step(input bit rst_v);
        bit pi, pd, gi, gd;
        @(posedge clk); #1;
        rst = rst_v;
        pi = (fq.size() > 0); pd = (dq.size() > 0);
        i_req = pi; d_req = pd;
        if (pi) begin i_addr = fq[0].addr; i_len = fq[0].len; end
        if (pd) begin
            d_we = dq[0].we; d_addr = dq[0].addr; d_len = dq[0].len;
            d_be = dq[0].be; d_wdata = dq[0].wdata;
        end
        gi = 0; gd = 0;
        if (rst_v && cyc >= free_cyc && (pi || pd)) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            gd = pd && !(pi && m_last_d);
            m_last_d = gd;
`else
            gd = pd;
`endif
            gi = !gd;
            if (gd) begin sched(1, dq[0]); void'(dq.pop_front()); end
            else    begin sched(0, fq[0]); void'(fq.pop_front()); end
        end
        exp_ignt = gi; exp_dgnt = gd;
        if (!rst_v) begin
            // sampled reset abandons everything from the next cycle on
            for (int i = cyc + 1; i < cyc + 100 && i < MAXC; i++) ex[i] = e0;
            free_cyc = cyc + 1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            m_last_d = 1'b0;
`endif
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        do begin step(1); n++; end
        while ((fq.size() > 0 || dq.size() > 0 || cyc < free_cyc) && n < budget);
        if (n >= budget) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: got %0d cycles expected < %0d", n, budget);
        end
    endtask

    function automatic txn_t mk(input bit we, input logic [19:0] a, input logic [3:0] len,
                                input logic [3:0] be, input logic [31:0] wd);
        txn_t t;
        t.we = we; t.addr = a; t.len = len; t.be = be; t.wdata = wd;
        return t;
    endfunction

    // asynchronous SRAM chip driven purely by the pins
    initial forever begin
        @(negedge clk);
        if (!sram_ce_n && !sram_we_n)
            chip[int'(sram_addr)] = merge(chip_rd(sram_addr), sram_dout, ~sram_be_n);
        sram_din = (!sram_ce_n && !sram_oe_n) ? chip_rd(sram_addr) : 32'hDEADBEEF;
    end

    // per-cycle compare against the timeline model
    initial forever begin
        exp_t e;
        beat_t bt;
        @(negedge clk);
        if (chk_en && cyc < MAXC) begin
            e = ex[cyc];
            chk("i_gnt", i_gnt, exp_ignt);
            chk("d_gnt", d_gnt, exp_dgnt);
            chk("busy", busy, e.busy);
            chk("ce_n", sram_ce_n, !e.ce);
            chk("oe_n", sram_oe_n, !e.oe);
            chk("we_n", sram_we_n, !e.we);
            chk("dout_en", sram_dout_en, e.den);
            chk("be_n", sram_be_n, e.ce ? e.ben : 4'hF);
            chk("i_rvalid", i_rvalid, e.iv);
            chk("i_rlast", i_rlast, e.il);
            chk("d_rvalid", d_rvalid, e.dv);
            chk("d_rlast", d_rlast, e.dl);
            chk("d_bvalid", d_bvalid, e.bv);
            if (e.ce)  chk("sram_addr", sram_addr, e.addr);
            if (e.den) chk("sram_dout", sram_dout, e.dout);
            if (e.iv)  chk("i_rdata", i_rdata, e.rdata);
            if (e.dv)  chk("d_rdata", d_rdata, e.rdata);
            chk("oe_we_overlap", (!sram_oe_n && !sram_we_n), 0);
            chk("den_oe_overlap", (sram_dout_en && !sram_oe_n), 0);
            if (i_gnt) begin grants.push_back(1'b0); gnt_cyc = cyc; end
            if (d_gnt) begin grants.push_back(1'b1); gnt_cyc = cyc; end
            if (i_rvalid || d_rvalid) begin
                bt.c = cyc; bt.isd = d_rvalid;
                bt.data = d_rvalid ? d_rdata : i_rdata;
                bt.last = d_rvalid ? d_rlast : i_rlast;
                beats.push_back(bt);
            end
            if (d_bvalid) bv_cyc = cyc;
            if (!sram_we_n) begin we_cnt++; if (we_first < 0) we_first = cyc; end
            if (!sram_oe_n) oe_cnt++;
            if (!sram_ce_n) ben_seen = sram_be_n;
        end
    end

    initial begin
        logic [31:0] bexp[4];
        int g, nb;
        bexp[0] = 32'hC0DFFFFE; bexp[1] = 32'hC0DFFFFF;
        bexp[2] = 32'hC0D00000; bexp[3] = 32'hC0D00001;

        // reset
        step(0);
        chk_en = 1'b1;
        step(0); step(0);
        chk("rst_addr", sram_addr, 20'h0);
        chk("rst_dout", sram_dout, 32'h0);
        chk("rst_be_n", sram_be_n, 4'hF);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_busy", busy, 1'b0);

        // single fetch
        clr_log();
        fq.push_back(mk(0, 20'h00010, 4'd0, 4'hF, 32'h0));
        drain(100);
        chk("f1_beats", beats.size(), 1);
        if (beats.size() == 1) begin
            chk("f1_lat", beats[0].c - gnt_cyc, 4);
            chk("f1_data", beats[0].data, 32'hC0D00010);
            chk("f1_last", beats[0].last, 1'b1);
        end
        chk("f1_oe_cycles", oe_cnt, 3);

        // partial write then read back
        clr_log();
        dq.push_back(mk(1, 20'h00020, 4'd0, 4'b0011, 32'hAABBCCDD));
        drain(100);
        chk("wr_bvalid_lat", bv_cyc - gnt_cyc, 5);
        chk("wr_we_cycles", we_cnt, 2);
        chk("wr_we_setup", we_first - gnt_cyc, 2);
        chk("wr_be_n", ben_seen, 4'b1100);
        clr_log();
        dq.push_back(mk(0, 20'h00020, 4'd0, 4'hF, 32'h0));
        drain(100);
        chk("rb_beats", beats.size(), 1);
        if (beats.size() == 1) chk("rb_data", beats[0].data, 32'hC0D0CCDD);

        // wrapping fetch burst
        clr_log();
        fq.push_back(mk(0, 20'hFFFFE, 4'd3, 4'hF, 32'h0));
        drain(200);
        chk("bu_beats", beats.size(), 4);
        if (beats.size() == 4) begin
            chk("bu_first_lat", beats[0].c - gnt_cyc, 4);
            for (int k = 0; k < 4; k++) begin
                chk("bu_data", beats[k].data, bexp[k]);
                chk("bu_last", beats[k].last, (k == 3));
                if (k > 0) chk("bu_spacing", beats[k].c - beats[k-1].c, 4);
            end
        end

        // simultaneous requests, then a second tie with data re-requesting
        clr_log();
        fq.push_back(mk(0, 20'h00030, 4'd0, 4'hF, 32'h0));
        dq.push_back(mk(0, 20'h00031, 4'd0, 4'hF, 32'h0));
        dq.push_back(mk(0, 20'h00032, 4'd0, 4'hF, 32'h0));
        drain(200);
        chk("tie_count", grants.size(), 3);
        if (grants.size() == 3) begin
            chk("tie_first", grants[0], 1'b1);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            chk("tie_second", grants[1], 1'b0);
            chk("tie_third", grants[2], 1'b1);
`else
            chk("tie_second", grants[1], 1'b1);
            chk("tie_third", grants[2], 1'b0);
`endif
        end

        // reset during RD count 1 of a fetch
        clr_log();
        fq.push_back(mk(0, 20'h00040, 4'd0, 4'hF, 32'h0));
        step(1); g = cyc;
        step(1);
        step(0);
        step(1);
        chk("rst_mid_ce_n", sram_ce_n, 1'b1);
        chk("rst_mid_oe_n", sram_oe_n, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_gap", cyc - g, 3);
        for (int i = 0; i < 12; i++) step(1);
        chk("rst_mid_no_rvalid", beats.size(), 0);

        // random mixed traffic on a small address window
        clr_log();
        n_exp_beats = 0;
        for (int n = 0; n < 24; n++) begin
            nb = $urandom_range(0, 5);
            for (int w = 0; w < nb; w++) step(1);
            if ($urandom_range(0, 1) == 1)
                fq.push_back(mk(0, 20'h00100 + 20'($urandom_range(0, 15)),
                                4'($urandom_range(0, 3)), 4'hF, 32'h0));
            else if ($urandom_range(0, 1) == 1)
                dq.push_back(mk(1, 20'h00100 + 20'($urandom_range(0, 15)), 4'd0,
                                4'($urandom_range(0, 15)), $urandom));
            else
                dq.push_back(mk(0, 20'h00100 + 20'($urandom_range(0, 15)),
                                4'($urandom_range(0, 3)), 4'hF, 32'h0));
        end
        drain(3000);
        chk("rand_beat_count", beats.size(), n_exp_beats);

        step(1); step(1);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
